mux_escritura_registros: RTL and testbench
==========================================

MUX_ESCRITURA_REGISTROS -- requirements
Module: mux_escritura_registros

Interface
REQ-001 Parameter WIDTH, default 8, data width of every source and of the output.
REQ-002 Parameter N_ENTRADAS, default 4, number of selectable sources (>= 2).
REQ-003 Derived localparam SEL_W = clog2(N_ENTRADAS) (min 1), selector width; not user-overridable.
REQ-004 i_Clk  input  1  single clock; all state on rising edge.
REQ-005 i_Reset  input  1  asynchronous, active-high reset.
REQ-006 i_Selector  input  SEL_W  source index; source k occupies i_Entradas[k*WIDTH +: WIDTH].
REQ-007 i_Entradas  input  N_ENTRADAS*WIDTH  packed sources (default order: 0 resultado, 1 direccionamiento inmediato, 2 bus de datos, 3 senal a stack).
REQ-008 i_Valido  input  1  upstream offers selector+sources this cycle.
REQ-009 o_Listo  output  1  block can accept; registered, not combinationally dependent on i_Listo.
REQ-010 o_Datos  output  WIDTH  selected, registered data.
REQ-011 o_Error  output  1  qualifies o_Datos: selector was >= N_ENTRADAS.
REQ-012 o_Valido  output  1  o_Datos/o_Error hold a valid word.
REQ-013 i_Listo  input  1  downstream (register file) accepts this cycle.

Function
REQ-014 Accept event SHALL be i_Valido && o_Listo at a rising edge; the word captured is source[i_Selector] at that edge.
REQ-015 Out-of-range selector SHALL capture data 0 with error flag 1; in range, error flag 0.
REQ-016 Storage SHALL be two stages: output register (OUT) and skid register (SKID), each holding data+error+valid.
REQ-017 Latency: accepted word SHALL appear on o_Datos with o_Valido=1 the cycle after acceptance when OUT is empty or drained that edge.
REQ-018 Output transfer SHALL be o_Valido && i_Listo; o_Datos/o_Error SHALL stay stable while o_Valido=1 and i_Listo=0.
REQ-019 Accept with OUT empty, or OUT draining and SKID empty: word SHALL load OUT.
REQ-020 Accept with OUT full and not draining: word SHALL load SKID; o_Listo SHALL go 0 next cycle.
REQ-021 SKID full and OUT drains: SKID SHALL move to OUT, SKID empties, o_Listo returns 1 next cycle.
REQ-022 o_Listo SHALL equal NOT SKID-valid (registered); no accept possible while SKID full.
REQ-023 Simultaneous accept and drain with SKID empty: new word SHALL replace OUT with no bubble (full throughput, 1 word/cycle).
REQ-024 Order SHALL be preserved: no word lost, duplicated, or reordered.
REQ-025 i_Selector/i_Entradas SHALL be ignored in any cycle without an accept event.
REQ-026 States (by valid bits): EMPTY (0,0), UNO (OUT only), LLENO (OUT+SKID); no other state reachable.

Reset
REQ-027 i_Reset SHALL immediately (asynchronously) clear: o_Valido=0, SKID valid=0, o_Listo=1, o_Datos=0, o_Error=0.
REQ-028 Reset mid-operation SHALL discard both stored words; no partial word emitted after release.
REQ-029 First accept SHALL be possible on the first rising edge after i_Reset deasserts.

Verification
REQ-030 Defaults, i_Listo=1, sources {0xCE,0x01,0xD5,0xFF}, selector 0,1,2,3 on consecutive cycles with i_Valido=1 -> o_Datos 0xCE,0x01,0xD5,0xFF on the following four cycles, o_Valido=1, o_Error=0.
REQ-031 N_ENTRADAS=3, selector=3, source word nonzero -> o_Datos=0x00, o_Error=1, o_Valido=1 next cycle.
REQ-032 i_Listo=0, two accepts (0x11, 0x22) -> o_Datos holds 0x11, o_Listo=0; raise i_Listo -> 0x11 then 0x22 transferred, o_Listo back to 1.
REQ-033 Continuous i_Valido=1, i_Listo=1 for 16 cycles -> 16 words out in order, o_Listo never 0.
REQ-034 State LLENO, assert i_Reset asynchronously between edges -> o_Valido=0, o_Listo=1, o_Datos=0 before next edge; no stale word after release.
REQ-035 WIDTH=16, N_ENTRADAS=8, random selectors and random i_Listo backpressure -> output stream matches scoreboard exactly.

Source files
------------

// File: rtl/mux_escritura_registros.sv
// -----------------------------------------------------------------------------
// mux_escritura_registros
//
// Register-file write-source multiplexer with a two-stage registered output
// (output register OUT + skid register SKID). One source word is captured per
// accept event and presented to the register file with valid/ready flow control.
//
// Handshake semantics (both sides):
//   A word moves across an interface on a rising edge where valid && ready.
//   Upstream:   i_Valido (valid) / o_Listo (ready). o_Listo is a pure decode of
//               registered state, never combinationally dependent on i_Listo.
//   Downstream: o_Valido (valid) / i_Listo (ready). While o_Valido=1 and
//               i_Listo=0, o_Datos/o_Error hold steady.
//
// Ports:
//   i_Clk        clock, all state on rising edge
//   i_Reset      asynchronous active-high reset
//   i_Selector   source index (SEL_W bits)
//   i_Entradas   packed sources, source k at [k*WIDTH +: WIDTH]
//                (0 resultado, 1 direccionamiento inmediato, 2 bus de datos,
//                 3 senal a stack)
//   i_Valido     upstream offers selector + sources this cycle
//   o_Listo      block can accept a word (NOT skid-valid)
//   o_Datos      selected, registered data
//   o_Error      o_Datos came from an out-of-range selector (data forced to 0)
//   o_Valido     o_Datos/o_Error hold a valid word
//   i_Listo      downstream accepts this cycle
//   estado       debug view of the state: {skid_valid, out_valid}
// -----------------------------------------------------------------------------
module mux_escritura_registros #(
    parameter  int WIDTH      = 8,
    parameter  int N_ENTRADAS = 4,
    localparam int SEL_W      = (N_ENTRADAS > 1) ? $clog2(N_ENTRADAS) : 1
) (
    input  logic                          i_Clk,
    input  logic                          i_Reset,
    input  logic [SEL_W-1:0]              i_Selector,
    input  logic [N_ENTRADAS*WIDTH-1:0]   i_Entradas,
    input  logic                          i_Valido,
    output logic                          o_Listo,
    output logic [WIDTH-1:0]              o_Datos,
    output logic                          o_Error,
    output logic                          o_Valido,
    input  logic                          i_Listo,
    output logic [1:0]                    estado
);

    // State encoding is literally {skid_valid, out_valid}, so the valid bits
    // and the debug output fall straight out of the state register.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        UNO   = 2'b01,
        LLENO = 2'b11
    } estado_t;

    estado_t            estado_q, estado_d;
    logic [WIDTH-1:0]   out_datos_q, out_datos_d;
    logic               out_error_q, out_error_d;
    logic [WIDTH-1:0]   skid_datos_q, skid_datos_d;
    logic               skid_error_q, skid_error_d;

    logic [WIDTH-1:0]   palabra_datos;
    logic               palabra_error;
    logic               accept;
    logic               drain;

    // Source selection. Searching over the legal indices (instead of a
    // variable part-select) keeps an out-of-range selector from ever
    // addressing past the packed vector; no match means error with data 0.
    always_comb begin
        palabra_datos = '0;
        palabra_error = 1'b1;
        for (int k = 0; k < N_ENTRADAS; k++) begin
            if (i_Selector == SEL_W'(k)) begin
                palabra_datos = i_Entradas[k*WIDTH +: WIDTH];
                palabra_error = 1'b0;
            end
        end
    end

    assign accept = i_Valido && o_Listo;
    assign drain  = o_Valido && i_Listo;

    // State register (with the data it qualifies).
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            estado_q     <= EMPTY;
            out_datos_q  <= '0;
            out_error_q  <= 1'b0;
            skid_datos_q <= '0;
            skid_error_q <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            out_datos_q  <= out_datos_d;
            out_error_q  <= out_error_d;
            skid_datos_q <= skid_datos_d;
            skid_error_q <= skid_error_d;
        end
    end

    // Next-state and next-data logic.
    always_comb begin
        estado_d     = estado_q;
        out_datos_d  = out_datos_q;
        out_error_d  = out_error_q;
        skid_datos_d = skid_datos_q;
        skid_error_d = skid_error_q;
        case (estado_q)
            EMPTY: begin
                if (accept) begin
                    estado_d    = UNO;
                    out_datos_d = palabra_datos;
                    out_error_d = palabra_error;
                end
            end
            UNO: begin
                if (accept && drain) begin
                    // Replace OUT in place: full throughput, no bubble.
                    out_datos_d = palabra_datos;
                    out_error_d = palabra_error;
                end else if (accept) begin
                    // OUT is stalled, park the new word in SKID.
                    estado_d     = LLENO;
                    skid_datos_d = palabra_datos;
                    skid_error_d = palabra_error;
                end else if (drain) begin
                    estado_d = EMPTY;
                end
            end
            LLENO: begin
                // o_Listo is 0 here, so no accept can happen.
                if (drain) begin
                    estado_d    = UNO;
                    out_datos_d = skid_datos_q;
                    out_error_d = skid_error_q;
                end
            end
            default: begin
                estado_d = EMPTY;
            end
        endcase
    end

    // Outputs: pure decode of registered state.
    always_comb begin
        o_Valido = estado_q[0];
        o_Listo  = ~estado_q[1];
        o_Datos  = out_datos_q;
        o_Error  = out_error_q;
        estado   = estado_q;
    end

endmodule

// File: tb/tb_mux_escritura_registros.sv
// -----------------------------------------------------------------------------
// tb_mux_escritura_registros
//
// Three instances: default (WIDTH=8, N=4), N=3 (out-of-range selector), and
// WIDTH=16, N=8 (random traffic). Instances A and C are checked against an
// occupancy-count reference model with an expected-word queue; instance B is
// checked with directed expectations.
// -----------------------------------------------------------------------------
module tb_mux_escritura_registros;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // ---------------- instance A: defaults ----------------
    logic [1:0]  a_sel;
    logic [31:0] a_ent;
    logic        a_ival, a_ilisto, a_olisto, a_oerr, a_oval;
    logic [7:0]  a_odat;
    logic [1:0]  a_est;

    mux_escritura_registros u_a (
        .i_Clk(clk), .i_Reset(rst), .i_Selector(a_sel), .i_Entradas(a_ent),
        .i_Valido(a_ival), .o_Listo(a_olisto), .o_Datos(a_odat),
        .o_Error(a_oerr), .o_Valido(a_oval), .i_Listo(a_ilisto), .estado(a_est)
    );

    // ---------------- instance B: N_ENTRADAS=3 ----------------
    logic [1:0]  b_sel;
    logic [23:0] b_ent;
    logic        b_ival, b_ilisto, b_olisto, b_oerr, b_oval;
    logic [7:0]  b_odat;
    logic [1:0]  b_est;

    mux_escritura_registros #(.WIDTH(8), .N_ENTRADAS(3)) u_b (
        .i_Clk(clk), .i_Reset(rst), .i_Selector(b_sel), .i_Entradas(b_ent),
        .i_Valido(b_ival), .o_Listo(b_olisto), .o_Datos(b_odat),
        .o_Error(b_oerr), .o_Valido(b_oval), .i_Listo(b_ilisto), .estado(b_est)
    );

    // ---------------- instance C: WIDTH=16, N_ENTRADAS=8 ----------------
    logic [2:0]   c_sel;
    logic [127:0] c_ent;
    logic         c_ival, c_ilisto, c_olisto, c_oerr, c_oval;
    logic [15:0]  c_odat;
    logic [1:0]   c_est;

    mux_escritura_registros #(.WIDTH(16), .N_ENTRADAS(8)) u_c (
        .i_Clk(clk), .i_Reset(rst), .i_Selector(c_sel), .i_Entradas(c_ent),
        .i_Valido(c_ival), .o_Listo(c_olisto), .o_Datos(c_odat),
        .o_Error(c_oerr), .o_Valido(c_oval), .i_Listo(c_ilisto), .estado(c_est)
    );

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected {error, data16} for a selector: source word, or 0 with error.
    function automatic logic [16:0] ref_word(input int sel, input logic [127:0] ent,
                                             input int w, input int n);
        logic [127:0] sh;
        if (sel >= n) return {1'b1, 16'h0000};
        sh = ent >> (sel * w);
        if (w == 8) return {1'b0, 8'h00, sh[7:0]};
        return {1'b0, sh[15:0]};
    endfunction

    // States by valid bits: 0 words -> 00, 1 word -> 01, 2 words -> 11.
    function automatic logic [1:0] ref_estado(input int cnt);
        if (cnt == 0) return 2'b00;
        if (cnt == 1) return 2'b01;
        return 2'b11;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model + scoreboard queues ----------------
    logic [16:0] a_q[$];
    logic [16:0] c_q[$];
    int a_cnt = 0;
    int c_cnt = 0;
    logic a_acc, a_drn, c_acc, c_drn;

    // Stimulus side: occupancy decides accepts; accepted words are pushed.
    always @(negedge clk) begin
        if (!rst) begin
            chk("a_valido", 32'(a_oval), 32'(a_cnt > 0));
            chk("a_listo", 32'(a_olisto), 32'(a_cnt < 2));
            chk("a_estado", 32'(a_est), 32'(ref_estado(a_cnt)));
            a_acc = a_ival && (a_cnt < 2);
            a_drn = (a_cnt > 0) && a_ilisto;
            if (a_acc) a_q.push_back(ref_word(int'(a_sel), {96'h0, a_ent}, 8, 4));
            a_cnt = a_cnt + int'(a_acc) - int'(a_drn);

            chk("c_valido", 32'(c_oval), 32'(c_cnt > 0));
            chk("c_listo", 32'(c_olisto), 32'(c_cnt < 2));
            chk("c_estado", 32'(c_est), 32'(ref_estado(c_cnt)));
            c_acc = c_ival && (c_cnt < 2);
            c_drn = (c_cnt > 0) && c_ilisto;
            if (c_acc) c_q.push_back(ref_word(int'(c_sel), c_ent, 16, 8));
            c_cnt = c_cnt + int'(c_acc) - int'(c_drn);
        end
    end

    // Monitor side: pops on every DUT output transfer, checks hold stability.
    logic        a_hold = 1'b0, c_hold = 1'b0;
    logic [8:0]  a_held;
    logic [16:0] c_held;
    logic [16:0] a_exp, c_exp;

    always @(negedge clk) begin
        if (rst) begin
            a_hold = 1'b0;
            c_hold = 1'b0;
        end else begin
            if (a_hold) chk("a_estable", 32'({a_oerr, a_odat}), 32'(a_held));
            if (a_oval && a_ilisto) begin
                if (a_q.size() == 0) begin
                    chk("a_extra_word", 32'({a_oerr, a_odat}), 32'h1ff00);
                end else begin
                    a_exp = a_q.pop_front();
                    chk("a_dato", 32'({a_oerr, a_odat}), 32'({a_exp[16], a_exp[7:0]}));
                end
            end
            a_hold = a_oval && !a_ilisto;
            a_held = {a_oerr, a_odat};

            if (c_hold) chk("c_estable", 32'({c_oerr, c_odat}), 32'(c_held));
            if (c_oval && c_ilisto) begin
                if (c_q.size() == 0) begin
                    chk("c_extra_word", 32'({c_oerr, c_odat}), 32'h1ff00);
                end else begin
                    c_exp = c_q.pop_front();
                    chk("c_dato", 32'({c_oerr, c_odat}), 32'(c_exp));
                end
            end
            c_hold = c_oval && !c_ilisto;
            c_held = {c_oerr, c_odat};
        end
    end

    // Asynchronous reset between edges; outputs must clear before next edge.
    task automatic reset_mid();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_a_valido", 32'(a_oval), 32'd0);
        chk("rst_a_listo", 32'(a_olisto), 32'd1);
        chk("rst_a_datos", 32'(a_odat), 32'd0);
        chk("rst_a_error", 32'(a_oerr), 32'd0);
        chk("rst_a_estado", 32'(a_est), 32'd0);
        a_cnt = 0; a_q.delete(); a_hold = 1'b0;
        c_cnt = 0; c_q.delete(); c_hold = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    // ---------------- main stimulus ----------------
    initial begin
        rst = 1'b1;
        a_sel = '0; a_ent = '0; a_ival = 1'b0; a_ilisto = 1'b1;
        b_sel = '0; b_ent = '0; b_ival = 1'b0; b_ilisto = 1'b1;
        c_sel = '0; c_ent = '0; c_ival = 1'b0; c_ilisto = 1'b1;
        #1;
        chk("reset_a_valido", 32'(a_oval), 32'd0);
        chk("reset_a_listo", 32'(a_olisto), 32'd1);
        chk("reset_a_datos", 32'(a_odat), 32'd0);
        chk("reset_b_valido", 32'(b_oval), 32'd0);
        chk("reset_c_listo", 32'(c_olisto), 32'd1);

        // Sources {CE,01,D5,FF}, selectors 0..3 back to back; the first word
        // is offered before reset release so it lands on the first edge.
        a_ent  = 32'hFFD501CE;
        a_ival = 1'b1;
        a_sel  = 2'd0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        for (int i = 1; i < 4; i++) begin
            step();
            a_sel = 2'(i);
        end
        step();
        a_ival = 1'b0;
        repeat (3) step();

        // Backpressure: two accepts with i_Listo low, then release.
        a_ilisto = 1'b0;
        a_ent    = 32'h00002211;
        a_ival   = 1'b1;
        a_sel    = 2'd0;
        step();
        a_sel = 2'd1;
        step();
        a_ival = 1'b0;
        repeat (3) step();
        a_ilisto = 1'b1;
        repeat (4) step();

        // Streaming: 16 words with i_Listo held high.
        for (int i = 0; i < 16; i++) begin
            a_ival = 1'b1;
            a_sel  = 2'($urandom_range(0, 3));
            a_ent  = $urandom;
            step();
        end
        a_ival = 1'b0;
        repeat (3) step();

        // Fill both stages, then reset between edges.
        a_ilisto = 1'b0;
        a_ival   = 1'b1;
        a_ent    = 32'h44332211;
        a_sel    = 2'd2;
        step();
        a_sel = 2'd3;
        step();
        a_ival = 1'b0;
        step();
        reset_mid();
        a_ilisto = 1'b1;
        repeat (3) step();

        // Instance B: out-of-range and in-range selectors.
        b_ival = 1'b1;
        b_sel  = 2'd3;
        b_ent  = 24'hA5C33C;
        step();
        b_ival = 1'b0;
        @(negedge clk);
        chk("b_oor_datos", 32'(b_odat), 32'h00);
        chk("b_oor_error", 32'(b_oerr), 32'd1);
        chk("b_oor_valido", 32'(b_oval), 32'd1);
        step();
        b_ival = 1'b1;
        b_sel  = 2'd2;
        step();
        b_ival = 1'b0;
        @(negedge clk);
        chk("b_in_datos", 32'(b_odat), 32'hA5);
        chk("b_in_error", 32'(b_oerr), 32'd0);
        chk("b_in_valido", 32'(b_oval), 32'd1);
        chk("b_listo", 32'(b_olisto), 32'd1);
        step();

        // Random traffic with random backpressure on A and C.
        for (int i = 0; i < 400; i++) begin
            a_ival   = 1'($urandom_range(0, 1));
            a_ilisto = ($urandom_range(0, 3) != 0);
            a_sel    = 2'($urandom_range(0, 3));
            a_ent    = $urandom;
            c_ival   = ($urandom_range(0, 3) != 0);
            c_ilisto = 1'($urandom_range(0, 1));
            c_sel    = 3'($urandom_range(0, 7));
            for (int j = 0; j < 4; j++) c_ent[j*32 +: 32] = $urandom;
            step();
        end
        a_ival = 1'b0; c_ival = 1'b0;
        a_ilisto = 1'b1; c_ilisto = 1'b1;
        repeat (5) step();

        chk("a_cola_vacia", 32'(a_q.size()), 32'd0);
        chk("c_cola_vacia", 32'(c_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
